// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared instruction/data memory with wait states.
// Define ARB_FIXED_PRIORITY_EN for core-first arbitration instead of round robin.
module mem_port_arbiter #(
   parameter int WIDTH       = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_req,
   input  logic             c_we,
   input  logic [WIDTH-1:0] c_adr,
   input  logic [WIDTH-1:0] c_wdata,
   output logic [WIDTH-1:0] c_rdata,
   output logic             c_ack,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [WIDTH-1:0] d_adr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic [WIDTH-1:0] d_rdata,
   output logic             d_ack,
   output logic             m_en,
   output logic             m_we,
   output logic [WIDTH-1:0] m_adr,
   output logic [WIDTH-1:0] m_wdata,
   input  logic [WIDTH-1:0] m_rdata,
   output logic             busy,
   output logic             grant
);

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t           state, state_nx;
   logic [3:0]       cnt;
   logic             last;
   logic             any_req;
   logic             win;
   logic             take;
   logic             we_q;
   logic [WIDTH-1:0] adr_q;
   logic [WIDTH-1:0] wdata_q;
   logic [WIDTH-1:0] rdata_q;

   assign any_req = c_req | d_req;
   assign last    = (cnt == LAST);
   assign take    = (state == IDLE) & any_req;

`ifdef ARB_FIXED_PRIORITY_EN
   assign win = ~c_req;
`else
   // rr_last remembers the previous winner; reset to debug so the core wins first
   logic rr_last;

   assign win = (c_req & d_req) ? ~rr_last : d_req;

   always_ff @(posedge clk) begin
      if (reset)     rr_last <= 1'b1;
      else if (take) rr_last <= win;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (any_req) state_nx = ACCESS;
         ACCESS:  if (last) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt     <= '0;
         grant   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (take) begin
         cnt     <= '0;
         grant   <= win;
         we_q    <= win ? d_we : c_we;
         adr_q   <= win ? d_adr : c_adr;
         wdata_q <= win ? d_wdata : c_wdata;
      end else if (state == ACCESS) begin
         if (!last)     cnt <= cnt + 4'd1;
         else if (!we_q) rdata_q <= m_rdata;
      end
   end

   // memory sees only the registered copy, and only while accessing
   assign m_en    = (state == ACCESS);
   assign m_we    = m_en & we_q;
   assign m_adr   = m_en ? adr_q : '0;
   assign m_wdata = m_en ? wdata_q : '0;
   assign busy    = (state == ACCESS) | (state == RESP);
   assign c_ack   = (state == RESP) & ~grant;
   assign d_ack   = (state == RESP) & grant;
   assign c_rdata = rdata_q;
   assign d_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed vector bench for mem_port_arbiter (WAIT_CYCLES=1).
// Each row: inputs applied before a rising edge, outputs expected after it.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, c_ack;
   logic [31:0] c_adr, c_wdata, c_rdata;
   logic        d_req, d_we, d_ack;
   logic [31:0] d_adr, d_wdata, d_rdata;
   logic        m_en, m_we, busy, grant;
   logic [31:0] m_adr, m_wdata, m_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.WIDTH(32), .WAIT_CYCLES(1)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .busy(busy), .grant(grant)
   );

   typedef struct {
      logic        rst;
      logic        cr, cw;
      logic [31:0] ca;
      logic        dr, dw;
      logic [31:0] da, dd, mr;
      logic        en, we;
      logic [31:0] adr, wd;
      logic        cak, dak;
      logic [31:0] rd;
      logic        bz, gn;
   } vec_t;

   vec_t vecs[$];

   task automatic add(
      input logic rst, cr, cw, input logic [31:0] ca,
      input logic dr, dw, input logic [31:0] da, dd, mr,
      input logic en, we, input logic [31:0] adr, wd,
      input logic cak, dak, input logic [31:0] rd,
      input logic bz, gn);
      vec_t v;
      v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca;
      v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
      v.en = en; v.we = we; v.adr = adr; v.wd = wd;
      v.cak = cak; v.dak = dak; v.rd = rd; v.bz = bz; v.gn = gn;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [133:0] got,
                        input logic [133:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] CF = 32'hCAFEF00D;
   localparam logic [31:0] WD = 32'h12345678;
   localparam logic [31:0] AA = 32'h5555AAAA;

   initial begin
      bit          fixed;
      logic        g, crn;
      logic [31:0] rdv, prev, adr;
      int          n;
`ifdef ARB_FIXED_PRIORITY_EN
      fixed = 1'b1;
`else
      fixed = 1'b0;
`endif
      // reset state
      add(1, 0,0,0,     0,0,0,0,0,    0,0,0,0,     0,0,0,  0,0);
      // core read 0x10
      add(0, 1,0,'h10,  0,0,0,0,0,    1,0,'h10,0,  0,0,0,  1,0);
      add(0, 1,0,'h10,  0,0,0,0,0,    1,0,'h10,0,  0,0,0,  1,0);
      add(0, 1,0,'h10,  0,0,0,0,DB,   0,0,0,0,     1,0,DB, 1,0);
      add(0, 0,0,'h10,  0,0,0,0,0,    0,0,0,0,     0,0,DB, 0,0);
      // debug write, rdata must hold
      add(0, 0,0,0,     1,1,'h200,WD,0,      1,1,'h200,WD, 0,0,DB, 1,1);
      add(0, 0,0,0,     1,1,'h200,WD,'1,     1,1,'h200,WD, 0,0,DB, 1,1);
      add(0, 0,0,0,     1,1,'h200,WD,'1,     0,0,0,0,      0,1,DB, 1,1);
      add(0, 0,0,0,     0,0,0,0,0,           0,0,0,0,      0,0,DB, 0,1);
      // core req dropped and address changed mid-access
      add(0, 1,0,'h40,  0,0,0,0,0,    1,0,'h40,0,  0,0,DB, 1,0);
      add(0, 0,0,'h99,  0,0,0,0,0,    1,0,'h40,0,  0,0,DB, 1,0);
      add(0, 0,0,'h99,  0,0,0,0,CF,   0,0,0,0,     1,0,CF, 1,0);
      add(0, 0,0,0,     0,0,0,0,0,    0,0,0,0,     0,0,CF, 0,0);
      // reset in the 2nd access cycle, then a fresh access
      add(0, 1,0,'h20,  0,0,0,0,0,    1,0,'h20,0,  0,0,CF, 1,0);
      add(0, 1,0,'h20,  0,0,0,0,0,    1,0,'h20,0,  0,0,CF, 1,0);
      add(1, 1,0,'h20,  0,0,0,0,'1,   0,0,0,0,     0,0,0,  0,0);
      add(0, 1,0,'h20,  0,0,0,0,0,    1,0,'h20,0,  0,0,0,  1,0);
      add(0, 1,0,'h20,  0,0,0,0,0,    1,0,'h20,0,  0,0,0,  1,0);
      add(0, 1,0,'h20,  0,0,0,0,AA,   0,0,0,0,     1,0,AA, 1,0);
      add(0, 0,0,0,     0,0,0,0,0,    0,0,0,0,     0,0,AA, 0,0);
      // both held from reset: four contended accesses, then debug alone
      add(1, 0,0,0,     0,0,0,0,0,    0,0,0,0,     0,0,0,  0,0);
      prev = 0;
      for (int k = 0; k < 5; k++) begin
         g   = (k == 4) ? 1'b1 : (fixed ? 1'b0 : k[0]);
         adr = g ? 32'h8 : 32'h4;
         rdv = 32'hA0000000 + k;
         crn = (k + 1) < 4;
         add(0, k<4,0,'h4, 1,0,'h8,0,0,   1,0,adr,0, 0,0,prev, 1,g);
         add(0, k<4,0,'h4, 1,0,'h8,0,0,   1,0,adr,0, 0,0,prev, 1,g);
         add(0, k<4,0,'h4, 1,0,'h8,0,rdv, 0,0,0,0,   ~g,g,rdv, 1,g);
         add(0, crn,0,'h4, k<4,0,'h8,0,0, 0,0,0,0,   0,0,rdv,  0,g);
         prev = rdv;
      end

      c_wdata = 0;
      foreach (vecs[i]) begin
         reset = vecs[i].rst;
         c_req = vecs[i].cr; c_we = vecs[i].cw; c_adr = vecs[i].ca;
         d_req = vecs[i].dr; d_we = vecs[i].dw; d_adr = vecs[i].da;
         d_wdata = vecs[i].dd; m_rdata = vecs[i].mr;
         @(posedge clk); #1;
         check($sformatf("row%0d", i),
               {m_en, m_we, m_adr, m_wdata, c_ack, d_ack,
                c_rdata, d_rdata, busy, grant},
               {vecs[i].en, vecs[i].we, vecs[i].adr, vecs[i].wd,
                vecs[i].cak, vecs[i].dak, vecs[i].rd, vecs[i].rd,
                vecs[i].bz, vecs[i].gn});
      end

      // hand-written latency check: ack exactly 3 edges after req in IDLE
      c_req = 1; c_we = 0; c_adr = 32'h30; d_req = 0;
      m_rdata = 32'h0BADF00D;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!c_ack && n < 20);
      c_req = 0;
      check("latency", 134'(n), 134'(3));
      check("lat_rdata", 134'(c_rdata), 134'(32'h0BADF00D));
      check("lat_dack", 134'(d_ack), 134'(0));
      @(posedge clk); #1;
      check("lat_idle", 134'({busy, m_en, c_ack}), 134'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
